// File: rtl/bitorder_stream_pkg.sv
// Shared types and width-generic reorder helpers for the bit/byte order stream.
package bitorder_stream_pkg;

  // Widest data bus supported; helpers work on this width and callers truncate.
  localparam int unsigned MAX_WIDTH = 512;

  typedef logic [MAX_WIDTH-1:0] wide_t;

  typedef enum logic [1:0] {
    PASS        = 2'd0,
    BITREV_BYTE = 2'd1,
    BYTESWAP    = 2'd2,
    BITREV_WORD = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_e;

  // Reverse the bit order inside each of the low nbytes bytes.
  function automatic wide_t bitrev_bytes(input wide_t d, input int unsigned nbytes);
    wide_t r;
    r = '0;
    for (int unsigned i = 0; i < nbytes; i++) begin
      for (int unsigned j = 0; j < 8; j++) begin
        r[8*i+j] = d[8*i+7-j];
      end
    end
    return r;
  endfunction

  // Swap byte i with byte nbytes-1-i across the low nbytes bytes.
  function automatic wide_t swap_bytes(input wide_t d, input int unsigned nbytes);
    wide_t r;
    r = '0;
    for (int unsigned i = 0; i < nbytes; i++) begin
      r[8*i +: 8] = d[8*(nbytes-1-i) +: 8];
    end
    return r;
  endfunction

  // Mirror the low nbits bits end for end.
  function automatic wide_t reverse_bits(input wide_t d, input int unsigned nbits);
    wide_t r;
    r = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      r[i] = d[nbits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bitorder_stream_stage.sv
// One elastic register stage: holds data/keep/last with a valid flag.
module bitorder_stage #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   up_data,
  input  logic [DATA_WIDTH/8-1:0] up_keep,
  input  logic                    up_last,
  input  logic                    up_valid,
  output logic                    up_ready,
  output logic [DATA_WIDTH-1:0]   dn_data,
  output logic [DATA_WIDTH/8-1:0] dn_keep,
  output logic                    dn_last,
  output logic                    dn_valid,
  input  logic                    dn_ready
);

  // Ready when empty or the held beat leaves this cycle.
  assign up_ready = !dn_valid || dn_ready;

  // Load a new beat (or go empty) whenever the slot is free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
      dn_keep  <= '0;
      dn_last  <= 1'b0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_data <= up_data;
        dn_keep <= up_keep;
        dn_last <= up_last;
      end
    end
  end

endmodule

// File: rtl/bitorder_stream.sv
// Streaming bit/byte reorder with per-packet mode latching, an elastic
// register pipeline and accepted beat/packet counters.
module bitorder_stream
  import bitorder_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [1:0]              active_mode,
  output logic [CNT_WIDTH-1:0]    beat_cnt,
  output logic [CNT_WIDTH-1:0]    pkt_cnt
);

  localparam int unsigned KW = DATA_WIDTH / 8;

  pkt_state_e state, state_next;
  mode_e      active_q;
  mode_e      eff_mode;
  logic       accept;

  logic [DATA_WIDTH-1:0] xf_data;
  logic [KW-1:0]         xf_keep;

  logic [DATA_WIDTH-1:0] stage_data  [PIPE_STAGES];
  logic [KW-1:0]         stage_keep  [PIPE_STAGES];
  logic                  stage_last  [PIPE_STAGES];
  logic                  stage_valid [PIPE_STAGES];
  logic                  stage_ready [PIPE_STAGES];

  assign s_tready = stage_ready[0];
  assign accept   = s_tvalid && s_tready;

  // Packet-boundary state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Any accepted beat ends in IDLE if it is the last, otherwise mid-packet.
  always_comb begin
    state_next = state;
    if (accept) state_next = s_tlast ? IDLE : IN_PKT;
  end

  // First beat of a packet uses the live mode; later beats the latched one.
  always_comb begin
    eff_mode = (state == IDLE) ? mode_e'(mode) : active_q;
  end

  // Latch the mode on the first accepted beat of each packet.
  always_ff @(posedge clk) begin
    if (!rst_n)                       active_q <= PASS;
    else if (accept && state == IDLE) active_q <= mode_e'(mode);
  end

  assign active_mode = active_q;

  // Reorder data and keep ahead of stage 0.
  always_comb begin
    xf_data = s_tdata;
    xf_keep = s_tkeep;
    case (eff_mode)
      BITREV_BYTE: begin
        xf_data = DATA_WIDTH'(bitrev_bytes(MAX_WIDTH'(s_tdata), KW));
      end
      BYTESWAP: begin
        xf_data = DATA_WIDTH'(swap_bytes(MAX_WIDTH'(s_tdata), KW));
        xf_keep = KW'(reverse_bits(MAX_WIDTH'(s_tkeep), KW));
      end
      BITREV_WORD: begin
        xf_data = DATA_WIDTH'(reverse_bits(MAX_WIDTH'(s_tdata), DATA_WIDTH));
        xf_keep = KW'(reverse_bits(MAX_WIDTH'(s_tkeep), KW));
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
    logic [DATA_WIDTH-1:0] up_data;
    logic [KW-1:0]         up_keep;
    logic                  up_last;
    logic                  up_valid;
    logic                  dn_ready;

    if (i == 0) begin : g_head
      assign up_data  = xf_data;
      assign up_keep  = xf_keep;
      assign up_last  = s_tlast;
      assign up_valid = s_tvalid;
    end else begin : g_body
      assign up_data  = stage_data[i-1];
      assign up_keep  = stage_keep[i-1];
      assign up_last  = stage_last[i-1];
      assign up_valid = stage_valid[i-1];
    end

    if (i == PIPE_STAGES - 1) begin : g_tail
      assign dn_ready = m_tready;
    end else begin : g_link
      assign dn_ready = stage_ready[i+1];
    end

    bitorder_stage #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .up_data (up_data),
      .up_keep (up_keep),
      .up_last (up_last),
      .up_valid(up_valid),
      .up_ready(stage_ready[i]),
      .dn_data (stage_data[i]),
      .dn_keep (stage_keep[i]),
      .dn_last (stage_last[i]),
      .dn_valid(stage_valid[i]),
      .dn_ready(dn_ready)
    );
  end

  assign m_tdata  = stage_data[PIPE_STAGES-1];
  assign m_tkeep  = stage_keep[PIPE_STAGES-1];
  assign m_tlast  = stage_last[PIPE_STAGES-1];
  assign m_tvalid = stage_valid[PIPE_STAGES-1];

  // Count accepted beats and accepted last beats; both wrap freely.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      if (s_tlast) pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_bitorder_stream.sv
// Scoreboard bench for bitorder_stream: a driver pushes expected beats at
// acceptance, a monitor pops and compares at each output transfer.
module tb_bitorder_stream;

  localparam int unsigned DW = 64;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned PS = 2;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    mode;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tlast;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [1:0]    active_mode;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] pkt_cnt;

  bitorder_stream #(
    .DATA_WIDTH (DW),
    .PIPE_STAGES(PS),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .s_tdata    (s_tdata),
    .s_tkeep    (s_tkeep),
    .s_tlast    (s_tlast),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tkeep    (m_tkeep),
    .m_tlast    (m_tlast),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .active_mode(active_mode),
    .beat_cnt   (beat_cnt),
    .pkt_cnt    (pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    int unsigned   acc_cyc;
    bit            chk_lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned out_times[$];
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int unsigned cyc    = 0;
  int unsigned bp     = 0;

  // Reference model state: packet framing and counters.
  bit            m_in_pkt = 1'b0;
  logic [1:0]    m_mode   = 2'd0;
  logic [CW-1:0] m_beats  = '0;
  logic [CW-1:0] m_pkts   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream readiness: 0 always ready, 1 random, 2 stalled.
  always @(negedge clk) begin
    case (bp)
      0:       m_tready = 1'b1;
      1:       m_tready = ($urandom_range(0, 3) != 0);
      default: m_tready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reorder rules from the mode definitions, using streaming operators.
  function automatic logic [DW-1:0] ref_data(input logic [DW-1:0] d, input logic [1:0] m);
    logic [DW-1:0] full;
    logic [DW-1:0] r;
    full = {<<{d}};
    case (m)
      2'd0:    r = d;
      2'd1:    r = {<<8{full}};
      2'd2:    r = {<<8{d}};
      default: r = full;
    endcase
    return r;
  endfunction

  function automatic logic [KW-1:0] ref_keep(input logic [KW-1:0] k, input logic [1:0] m);
    logic [KW-1:0] r;
    r = (m >= 2'd2) ? {<<{k}} : k;
    return r;
  endfunction

  // Present one beat until accepted; called at a falling edge, returns at one.
  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                      input logic [1:0] md, input bit lat, input bit use_exp,
                      input logic [DW-1:0] xd, input logic [KW-1:0] xk);
    int unsigned n;
    bit          done;
    exp_t        e;
    mode     = md;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    done     = 1'b0;
    n        = 0;
    while (!done && n < 300) begin
      #1;
      if (s_tready) begin
        if (!m_in_pkt) m_mode = md;
        m_in_pkt  = !l;
        e.d       = use_exp ? xd : ref_data(d, m_mode);
        e.k       = use_exp ? xk : ref_keep(k, m_mode);
        e.l       = l;
        e.acc_cyc = cyc;
        e.chk_lat = lat;
        sb.push_back(e);
        m_beats++;
        if (l) m_pkts++;
        done = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got no s_tready, expected acceptance within 300 cycles");
    end
    s_tvalid = 1'b0;
  endtask

  task automatic send_m(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                        input logic [1:0] md);
    send(d, k, l, md, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_counters();
    check("beat_cnt", DW'(beat_cnt), DW'(m_beats));
    check("pkt_cnt", DW'(pkt_cnt), DW'(m_pkts));
    check("active_mode", DW'(active_mode), DW'(m_mode));
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", DW'(sb.size()), '0);
  endtask

  // One-cycle reset at a falling edge; in-flight expectations are dropped.
  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    m_in_pkt = 1'b0;
    m_mode   = 2'd0;
    m_beats  = '0;
    m_pkts   = '0;
    #1;
    check("rst_m_tvalid", DW'(m_tvalid), '0);
    check("rst_m_tdata", m_tdata, '0);
    check("rst_m_tkeep", DW'(m_tkeep), '0);
    check("rst_m_tlast", DW'(m_tlast), '0);
    check("rst_beat_cnt", DW'(beat_cnt), '0);
    check("rst_pkt_cnt", DW'(pkt_cnt), '0);
    check("rst_active_mode", DW'(active_mode), '0);
    check("rst_s_tready", DW'(s_tready), DW'(1));
  endtask

  // Output monitor: pops on every transfer, checks stability under stall.
  logic [DW-1:0] hold_d;
  logic [KW-1:0] hold_k;
  logic          hold_l;
  bit            hold_v = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_valid", DW'(m_tvalid), DW'(1));
        check("stall_data", m_tdata, hold_d);
        check("stall_keep", DW'(m_tkeep), DW'(hold_k));
        check("stall_last", DW'(m_tlast), DW'(hold_l));
      end
      if (m_tvalid && m_tready) begin
        out_times.push_back(cyc);
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %h, expected no output", m_tdata);
        end else begin
          e = sb.pop_front();
          check("out_data", m_tdata, e.d);
          check("out_keep", DW'(m_tkeep), DW'(e.k));
          check("out_last", DW'(m_tlast), DW'(e.l));
          if (e.chk_lat) check("latency", DW'(cyc - e.acc_cyc), DW'(PS));
        end
      end
      hold_v = m_tvalid && !m_tready;
      hold_d = m_tdata;
      hold_k = m_tkeep;
      hold_l = m_tlast;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned base;
    rst_n    = 1'b0;
    mode     = 2'd0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(negedge clk);
    pulse_reset();
    @(negedge clk);

    // Directed reorders with literal expectations and latency checks.
    send(64'h0102_0304_0506_0708, 8'hFF, 1'b1, 2'd1, 1'b1, 1'b1, 64'h8040_C020_A060_E010, 8'hFF);
    check_counters();
    check("pkt_cnt_first", DW'(pkt_cnt), DW'(1));
    send(64'h1122_3344_5566_7788, 8'h0F, 1'b1, 2'd2, 1'b1, 1'b1, 64'h8877_6655_4433_2211, 8'hF0);
    check_counters();
    send(64'h0000_0000_0000_0001, 8'hFF, 1'b1, 2'd3, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 8'hFF);
    check_counters();
    wait_drain();

    // Mode change inside a packet only takes effect on the next packet.
    send(64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b0, 2'd0, 1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    send(64'hA5A5_0F0F_3C3C_1234, 8'h3C, 1'b0, 2'd2, 1'b0, 1'b1, 64'hA5A5_0F0F_3C3C_1234, 8'h3C);
    send(64'h0011_2233_4455_6677, 8'h01, 1'b1, 2'd2, 1'b0, 1'b1, 64'h0011_2233_4455_6677, 8'h01);
    check("mid_pkt_mode", DW'(active_mode), '0);
    check_counters();
    send(64'h0102_0304_0506_0708, 8'h81, 1'b1, 2'd2, 1'b0, 1'b1, 64'h0807_0605_0403_0201, 8'h81);
    check("next_pkt_mode", DW'(active_mode), DW'(2));
    wait_drain();

    // Backpressure: two beats buffer, then input stalls; all four emerge in order.
    pulse_reset();
    bp = 2;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 4; i++) send_m({$urandom, $urandom}, 8'hFF, (i == 3), 2'd1);
      end
    join_none
    repeat (5) @(negedge clk);
    #1;
    check("bp_s_tready", DW'(s_tready), '0);
    check("bp_beat_cnt", DW'(beat_cnt), DW'(2));
    check("bp_m_tvalid", DW'(m_tvalid), DW'(1));
    bp = 0;
    wait fork;
    wait_drain();
    check("bp_beats_total", DW'(beat_cnt), DW'(4));
    check_counters();

    // Reset mid-packet with beats in flight, then a fresh mode latch.
    bp = 2;
    @(negedge clk);
    send_m(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 2'd3);
    send_m(64'h5555_6666_7777_8888, 8'hFF, 1'b0, 2'd3);
    check("pre_rst_mode", DW'(active_mode), DW'(3));
    pulse_reset();
    bp = 0;
    @(negedge clk);
    send(64'h0102_0304_0506_0708, 8'hFF, 1'b1, 2'd1, 1'b1, 1'b1, 64'h8040_C020_A060_E010, 8'hFF);
    check("post_rst_mode", DW'(active_mode), DW'(1));
    check_counters();
    wait_drain();

    // Counter wrap and full-rate throughput: 17 one-beat packets back to back.
    pulse_reset();
    out_times.delete();
    for (int i = 0; i < 17; i++) begin
      send(
        {$urandom, $urandom}, KW'($urandom), 1'b1, 2'($urandom_range(0, 3)),
        1'b1, 1'b0, '0, '0
      );
    end
    check("wrap_beat_cnt", DW'(beat_cnt), DW'(1));
    check("wrap_pkt_cnt", DW'(pkt_cnt), DW'(1));
    wait_drain();
    check("rate_count", DW'(out_times.size()), DW'(17));
    if (out_times.size() == 17) begin
      check("rate_span", DW'(out_times[16] - out_times[0]), DW'(16));
    end

    // Randomized packets with idle gaps and random backpressure.
    bp = 1;
    for (int i = 0; i < 300; i++) begin
      base = $urandom_range(0, 2);
      repeat (base) @(negedge clk);
      send_m({$urandom, $urandom}, KW'($urandom), ($urandom_range(0, 3) == 0),
             2'($urandom_range(0, 3)));
      check_counters();
    end
    bp = 0;
    wait_drain();
    repeat (4) @(negedge clk);
    check("final_queue", DW'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bitorder_stream.md
Name: bitorder_stream

Overview:
- Streaming, parametrised successor to the packet-path bit/byte reordering helpers.
- Applies per-packet reorder modes to an AXI-Stream-style data path: pass, per-byte bit reverse, byte swap, or full-word bit reverse.
- Uses an elastic valid/ready pipeline with packet-boundary mode latching and beat/packet counters.
- Sits between the Ethernet RX/TX framing logic and the TLP/CRC logic wherever wire bit order differs from internal order.

Parameters:
- DATA_WIDTH, 64, data bus width in bits; multiple of 8, 8..512.
- PIPE_STAGES, 2, number of register stages, 1..4; sets latency.
- CNT_WIDTH, 32, width of the beat and packet counters.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  synchronous, active-low reset.
- mode  in  2  requested mode: 0 pass, 1 bit-reverse each byte, 2 byte swap, 3 full-word bit reverse.
- s_tdata  in  DATA_WIDTH  input beat data.
- s_tkeep  in  DATA_WIDTH/8  input byte enables.
- s_tlast  in  1  last beat of packet.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- m_tdata  out  DATA_WIDTH  output data.
- m_tkeep  out  DATA_WIDTH/8  output byte enables.
- m_tlast  out  1  output last.
- m_tvalid  out  1  output valid.
- m_tready  in  1  downstream ready.
- active_mode  out  2  mode latched for the packet currently entering.
- beat_cnt  out  CNT_WIDTH  accepted-beat count.
- pkt_cnt  out  CNT_WIDTH  accepted-packet count (tlast beats).

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all stage valids, so m_tvalid=0. Also clears m_tdata, m_tkeep, m_tlast, beat_cnt, pkt_cnt and active_mode to 0, and puts the FSM in IDLE. s_tready=1 the cycle after reset deasserts.
- Reset mid-packet discards all in-flight beats; nothing partial is emitted.
- Transfer occurs on a port when valid and ready are both 1 at a rising clk.
- Mode-latch FSM:
  - States IDLE and IN_PKT.
  - In IDLE, an accepted beat latches mode into active_mode and is processed with that mode. The FSM moves to IN_PKT unless s_tlast=1, in which case it stays in IDLE.
  - In IN_PKT, mode is ignored and beats use active_mode. An accepted beat with s_tlast=1 returns the FSM to IDLE.
  - The transform is computed combinationally from the latched or incoming mode at stage 0 input.
- Transforms:
  - Mode 0: data and keep unchanged.
  - Mode 1: byte i bit j maps to byte i bit 7-j; keep unchanged.
  - Mode 2: byte i maps to byte N-1-i, where N=DATA_WIDTH/8; keep bit i maps to N-1-i.
  - Mode 3: bit k maps to bit DATA_WIDTH-1-k; keep reversed as in mode 2.
  - tlast is never altered.
- Pipeline:
  - PIPE_STAGES register stages, each holding data, keep, last and a valid flag.
  - Stage i is ready when it is empty or stage i+1 accepts this cycle; the last stage uses m_tready.
  - s_tready equals stage 0 readiness, derived combinationally from downstream readiness through empty/advancing terms. No combinational path from s_tvalid to s_tready.
  - Latency: a beat accepted at edge t appears on m_* after edge t+PIPE_STAGES-1, provided no stall.
  - Throughput: one beat per cycle sustained with m_tready=1.
  - Under backpressure, data is held stable while m_tvalid=1 and m_tready=0. No beat is lost or duplicated.
- Counters:
  - beat_cnt increments by 1 per input transfer.
  - pkt_cnt increments per input transfer with s_tlast=1.
  - Both wrap modulo 2^CNT_WIDTH silently.
  - Both update at the accepting edge.
- Simultaneous events: a stage may accept and emit in the same cycle (full-rate passthrough). A mode change on the same cycle as a tlast beat affects only the next packet.

Decomposition:
- Shared package (extend the existing utils package):
  - A mode enum typedef: PASS, BITREV_BYTE, BYTESWAP, BITREV_WORD.
  - Width-generic functions for byte-bit reverse, byte swap and full reverse, written as loops over a parameterised width.
- One sub-module: bitorder_stage, a single elastic register stage (data/keep/last/valid with the ready rule), instantiated PIPE_STAGES times via generate.

Test Plan:
1. DATA_WIDTH=64, mode=1, single beat 0x0102_0304_0506_0708, keep=0xFF, last=1 -> m_tdata=0x8040_C020_A060_E010, keep=0xFF, 2 cycles after accept; pkt_cnt=1.
2. mode=2, beat 0x1122_3344_5566_7788, keep=0x0F -> m_tdata=0x8877_6655_4433_2211, m_tkeep=0xF0.
3. mode=3, beat 0x0000_0000_0000_0001 -> 0x8000_0000_0000_0000. Then a 3-beat packet with mode switched 0->2 after beat 1 -> all 3 beats in mode 0; active_mode becomes 2 only on the next packet.
4. Hold m_tready=0 for 5 cycles with a 4-beat stream (PIPE_STAGES=2) -> s_tready drops after 2 beats are buffered; the output is held stable; after release, all 4 beats arrive in order with no duplicates; beat_cnt=4.
5. Assert rst_n=0 for one cycle mid-packet with 2 beats in flight -> m_tvalid=0 next cycle; counters and active_mode=0; FSM in IDLE; the next beat latches a fresh mode.
6. CNT_WIDTH=4, 17 single-beat packets at full rate with m_tready=1 -> pkt_cnt=1 and beat_cnt=1 after wrap; output sustained at 1 beat/cycle.
